neuron_lif_layer: RTL and testbench
===================================

# neuron_lif_layer

Time-multiplexed layer of `NEURONS` leaky integrate-and-fire neurons sharing one membrane-update datapath. Accepts one input spike vector per time step over a valid/ready handshake, sweeps all neurons sequentially (one per cycle) against per-neuron binary weight rows, and returns the layer's spike vector over a second handshake. It adds an optional per-neuron refractory period. It sits between input spike sources and downstream layers, replacing per-neuron instances where area matters more than throughput.

## Interface
- `SYNAPSES`, 32: inputs per neuron; weight row width.
- `NEURONS`, 8: neurons in the layer, ≥2.
- `MEMBRANE_BITS`, `$clog2(SYNAPSES)+2`: signed membrane width.
- `THRESHOLD_BITS`, `MEMBRANE_BITS-1`: unsigned threshold width.
- `BATCHNORM_ADDEND_BITS`, `MEMBRANE_BITS-2`: signed addend width.
- `REFRACTORY_BITS`, 3: refractory counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1 / `in_ready` out 1: input step handshake.
- `inputs` in `SYNAPSES`: input spike vector, sampled on accept.
- `cfg_we` in 1, `cfg_addr` in `$clog2(NEURONS)`, `cfg_weights` in `SYNAPSES`: weight-row write port; `cfg_ready` out 1 indicates that writes are taken.
- `batchnorm_factor` in 4, `batchnorm_addend` in `BATCHNORM_ADDEND_BITS` (signed), `shift` in 3, `threshold` in `THRESHOLD_BITS`, `refractory_cycles` in `REFRACTORY_BITS`: layer-wide quasi-static configuration. These inputs must be held constant from accept until the output is consumed.
- `out_valid` out 1 / `out_ready` in 1: output step handshake.
- `out_spikes` out `NEURONS`: bit i = spike of neuron i for the completed step.
- `out_membrane` out `NEURONS*MEMBRANE_BITS`: stored membranes, neuron i at bits [i*MEMBRANE_BITS +: MEMBRANE_BITS].

## Operation
- FSM has three states: IDLE → RUN → DONE → IDLE.
- **IDLE:** `in_ready=1`, `cfg_ready=1`.
  - `cfg_we` writes `cfg_weights` into row `cfg_addr`.
  - `in_valid&&in_ready` latches `inputs`, clears index to 0, and moves to RUN.
  - If `cfg_we` and accept occur in the same cycle, the write lands first and is used by that step.
- **RUN:** one neuron per cycle, index 0..NEURONS-1.
  - The datapath reads `membrane[idx]` and `weights[idx]` and computes the new membrane and spike with `lif_logic` semantics:
    - ±1 binary-weight accumulate;
    - decay by `shift`;
    - batch-norm factor/addend;
    - threshold compare `u ≥ {0,threshold}`;
    - post-spike reset.
  - The new membrane is written back and the spike goes to `out_spikes[idx]` at the cycle's end.
  - After idx NEURONS-1 the FSM moves to DONE.
  - `in_ready=0` and `cfg_ready=0`; `cfg_we` is ignored.
- **DONE:** `out_valid=1`.
  - `out_spikes` and `out_membrane` hold stable until `out_valid&&out_ready`, then the FSM returns to IDLE.
- Refractory (macro enabled):
  - A spike loads `refr[idx] ← refractory_cycles`.
  - While `refr[idx]≠0` at that neuron's slot: membrane is unchanged, spike is forced 0, and `refr[idx]` decrements by 1.
  - `refractory_cycles=0` disables the refractory period.
- All arithmetic stays at `MEMBRANE_BITS` and is saturating inside the shared datapath; no wrap.
- Reset (async, any state, including mid-RUN):
  - state IDLE, index 0;
  - all membranes, weights, refr counters and `out_spikes` = 0;
  - `out_valid=0`;
  - `in_ready` and `cfg_ready` forced 0 while `reset` is high, 1 in the first cycle after deassertion.
  - A partially swept step is discarded.

## Timing
- Accept at cycle T → RUN spans T+1..T+NEURONS → `out_valid` high from T+NEURONS+1.
- Minimum step period is NEURONS+2 cycles (with `out_ready` held high).
- `in_ready` rises the cycle after output consumption.
- Back-to-back accept is impossible while RUN/DONE; `in_valid` may stay high.
- `out_membrane` updates per neuron during RUN; it is only meaningful while `out_valid=1` or in IDLE.
- No combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `NEURON_LIF_LAYER_REFRACTORY_EN` defined: refractory counters and gating as above.
- Undefined: no refr storage; `refractory_cycles` is ignored; every neuron integrates every step.

## Structure
- Shared package `neuron_lif_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`);
  - width helper localparams (membrane bits from synapse count);
  - the batch-norm neutral factor constant `BN_UNITY = 4'b0100`.
- One sub-module: a single shared `lif_logic` instance as the per-cycle datapath, muxed by index.
- Membrane, weight and refr arrays are flops, kept in this block.

## Test plan
Bench parameters: SYNAPSES=8, NEURONS=4 (MEMBRANE_BITS=5).
- **Reset values:** assert reset → `out_valid=0`, `out_spikes=0`, `out_membrane=0`; after release `in_ready=1`.
- **Integration:** all weights 0xFF, `inputs=0x0F`, shift 0, factor 4'b0100, addend 0, threshold 10 → membranes 4, 8 on steps 1–2, all neurons spike on step 3 (`out_spikes=4'hF`), post-spike membranes match the `lif_logic` model.
- **Per-neuron weights:** row0=0xFF, row1=0x00, others 0x0F with `inputs=0xFF` → membranes after step 1 are +8, −8, 0, 0 (saturated per model).
- **Latency and backpressure:** accept at T, `out_valid` at T+5; hold `out_ready=0` for 10 cycles → outputs stable, `in_ready=0`; release → IDLE next cycle.
- **Refractory (macro on):** `refractory_cycles=2`, neuron 0 spikes at step 3 → steps 4–5 spike=0 with membrane frozen; integration resumes at step 6.
- **Async reset mid-RUN:** reset at index 2 → state IDLE, no `out_valid`; next step starts from zero membranes.

Source files
------------

// File: rtl/neuron_lif_pkg.sv
// Shared definitions for the time-multiplexed LIF layer: FSM state encoding,
// membrane width helper and batch-norm fixed-point constants.
package neuron_lif_pkg;

  // Layer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Batch-norm factor is unsigned Q2.2, so 4'b0100 multiplies by exactly 1.0
  localparam logic [3:0] BN_UNITY     = 4'b0100;
  localparam int         BN_FRAC_BITS = 2;

  // Membrane must hold +/-SYNAPSES plus one bit of integration headroom
  function automatic int membrane_bits_for(input int synapses);
    return $clog2(synapses) + 2;
  endfunction

  localparam int DEFAULT_SYNAPSES      = 32;
  localparam int DEFAULT_MEMBRANE_BITS = membrane_bits_for(DEFAULT_SYNAPSES);

endpackage

// File: rtl/neuron_lif_layer_lif_logic.sv
// Shared single-neuron membrane update: leak, +/-1 binary-weight accumulate,
// batch-norm scale/offset, threshold compare and reset-to-zero after a spike.
// Every stage saturates to MEMBRANE_BITS; internal math is carried wider so
// nothing wraps before the clamp.
module lif_logic
  import neuron_lif_pkg::*;
#(
  parameter int SYNAPSES              = DEFAULT_SYNAPSES,
  parameter int MEMBRANE_BITS         = membrane_bits_for(SYNAPSES),
  parameter int THRESHOLD_BITS        = MEMBRANE_BITS - 1,
  parameter int BATCHNORM_ADDEND_BITS = MEMBRANE_BITS - 2
) (
  input  logic signed [MEMBRANE_BITS-1:0]         membrane,
  input  logic        [SYNAPSES-1:0]              weights,
  input  logic        [SYNAPSES-1:0]              inputs,
  input  logic        [3:0]                       batchnorm_factor,
  input  logic signed [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
  input  logic        [2:0]                       shift,
  input  logic        [THRESHOLD_BITS-1:0]        threshold,
  output logic signed [MEMBRANE_BITS-1:0]         membrane_next,
  output logic                                    spike
);

  localparam int WIDE = MEMBRANE_BITS + 8;
  localparam logic signed [WIDE-1:0] ONE   = WIDE'(1);
  localparam logic signed [WIDE-1:0] U_MAX = WIDE'((1 << (MEMBRANE_BITS - 1)) - 1);
  localparam logic signed [WIDE-1:0] U_MIN = -U_MAX - ONE;

  function automatic logic signed [MEMBRANE_BITS-1:0] saturate(input logic signed [WIDE-1:0] v);
    if (v > U_MAX) return U_MAX[MEMBRANE_BITS-1:0];
    if (v < U_MIN) return U_MIN[MEMBRANE_BITS-1:0];
    return v[MEMBRANE_BITS-1:0];
  endfunction

  logic signed [WIDE-1:0]          syn_sum;
  logic signed [WIDE-1:0]          u_wide;
  logic signed [WIDE-1:0]          leak;
  logic signed [MEMBRANE_BITS-1:0] accum_sat;
  logic signed [WIDE-1:0]          product;
  logic signed [WIDE-1:0]          scaled;
  logic signed [MEMBRANE_BITS-1:0] bn_sat;

  // Active inputs add +1 through a set weight bit and -1 through a clear one
  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (inputs[i]) begin
        if (weights[i]) syn_sum = syn_sum + ONE;
        else            syn_sum = syn_sum - ONE;
      end
    end
  end

  // Leak (u - u>>>shift, none when shift is 0), integrate, scale, compare
  always_comb begin
    u_wide = WIDE'(membrane);
    leak   = '0;
    if (shift != 3'd0) leak = u_wide >>> shift;
    accum_sat     = saturate(u_wide - leak + syn_sum);
    product       = WIDE'(accum_sat) * signed'(WIDE'({1'b0, batchnorm_factor}));
    scaled        = (product >>> BN_FRAC_BITS) + WIDE'(batchnorm_addend);
    bn_sat        = saturate(scaled);
    spike         = WIDE'(bn_sat) >= signed'(WIDE'({1'b0, threshold}));
    membrane_next = spike ? '0 : bn_sat;
  end

endmodule

// File: rtl/neuron_lif_layer.sv
// Layer of NEURONS leaky integrate-and-fire neurons sharing one lif_logic
// datapath, swept one neuron per clock after each accepted input step.
// Optional per-neuron refractory period: NEURON_LIF_LAYER_REFRACTORY_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready/cfg_ready depend only on state and reset, out_valid only on
// state, so neither in_valid nor out_ready reaches any output
// combinationally. Once asserted, out_valid stays high with stable data
// until out_ready is seen.
module neuron_lif_layer
  import neuron_lif_pkg::*;
#(
  parameter int SYNAPSES              = DEFAULT_SYNAPSES,
  parameter int NEURONS               = 8,
  parameter int MEMBRANE_BITS         = membrane_bits_for(SYNAPSES),
  parameter int THRESHOLD_BITS        = MEMBRANE_BITS - 1,
  parameter int BATCHNORM_ADDEND_BITS = MEMBRANE_BITS - 2,
  parameter int REFRACTORY_BITS       = 3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SYNAPSES-1:0]                     inputs,
  input  logic                                    cfg_we,
  input  logic [$clog2(NEURONS)-1:0]              cfg_addr,
  input  logic [SYNAPSES-1:0]                     cfg_weights,
  output logic                                    cfg_ready,
  input  logic [3:0]                              batchnorm_factor,
  input  logic signed [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
  input  logic [2:0]                              shift,
  input  logic [THRESHOLD_BITS-1:0]               threshold,
  input  logic [REFRACTORY_BITS-1:0]              refractory_cycles,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NEURONS-1:0]                      out_spikes,
  output logic [NEURONS*MEMBRANE_BITS-1:0]        out_membrane,
  output state_t                                  dbg_state
);

  localparam int IDX_BITS = $clog2(NEURONS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NEURONS - 1);

  state_t                          state, state_next;
  logic [IDX_BITS-1:0]             idx;
  logic [SYNAPSES-1:0]             in_q;
  logic [SYNAPSES-1:0]             weights_q [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] mem_q     [NEURONS];
  logic [NEURONS-1:0]              spikes_q;
  logic                            accept;
  logic signed [MEMBRANE_BITS-1:0] lif_membrane, upd_membrane;
  logic                            lif_spike, upd_spike;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs; ready is held low during reset
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cfg_ready  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready  = !reset;
        cfg_ready = !reset;
        if (in_valid && !reset) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (idx == LAST_IDX) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  lif_logic #(
    .SYNAPSES              (SYNAPSES),
    .MEMBRANE_BITS         (MEMBRANE_BITS),
    .THRESHOLD_BITS        (THRESHOLD_BITS),
    .BATCHNORM_ADDEND_BITS (BATCHNORM_ADDEND_BITS)
  ) u_lif (
    .membrane         (mem_q[idx]),
    .weights          (weights_q[idx]),
    .inputs           (in_q),
    .batchnorm_factor (batchnorm_factor),
    .batchnorm_addend (batchnorm_addend),
    .shift            (shift),
    .threshold        (threshold),
    .membrane_next    (lif_membrane),
    .spike            (lif_spike)
  );

`ifdef NEURON_LIF_LAYER_REFRACTORY_EN
  logic [REFRACTORY_BITS-1:0] refr_q [NEURONS];

  // Refractory neuron keeps its membrane and stays silent for this slot
  always_comb begin
    upd_membrane = lif_membrane;
    upd_spike    = lif_spike;
    if (refr_q[idx] != '0) begin
      upd_membrane = mem_q[idx];
      upd_spike    = 1'b0;
    end
  end

  // Count down an active refractory period, or arm it on a fresh spike
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NEURONS; i++) refr_q[i] <= '0;
    end else if (state == ST_RUN) begin
      if (refr_q[idx] != '0) refr_q[idx] <= refr_q[idx] - 1'b1;
      else if (lif_spike)    refr_q[idx] <= refractory_cycles;
    end
  end
`else
  logic unused_refractory;
  assign unused_refractory = ^refractory_cycles;
  assign upd_membrane      = lif_membrane;
  assign upd_spike         = lif_spike;
`endif

  // Weight writes and step capture in IDLE, one neuron write-back per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      in_q     <= '0;
      spikes_q <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        weights_q[i] <= '0;
        mem_q[i]     <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_we) weights_q[cfg_addr] <= cfg_weights;
          if (accept) begin
            in_q <= inputs;
            idx  <= '0;
          end
        end
        ST_RUN: begin
          mem_q[idx]    <= upd_membrane;
          spikes_q[idx] <= upd_spike;
          idx           <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_spikes = spikes_q;

  for (genvar g = 0; g < NEURONS; g++) begin : g_pack
    assign out_membrane[g*MEMBRANE_BITS +: MEMBRANE_BITS] = mem_q[g];
  end

endmodule

// File: tb/tb_neuron_lif_layer.sv
// Directed bench for neuron_lif_layer with SYNAPSES=8, NEURONS=4 (5-bit
// membranes). Expected values are hand-computed from the LIF update rule.
// Refractory expectations follow NEURON_LIF_LAYER_REFRACTORY_EN.
module tb_neuron_lif_layer;
  import neuron_lif_pkg::*;

  localparam int SYN = 8;
  localparam int NEU = 4;
  localparam int MB  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SYN-1:0]    inputs = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic [SYN-1:0]    cfg_weights = '0;
  logic              cfg_ready;
  logic [3:0]        batchnorm_factor = BN_UNITY;
  logic signed [2:0] batchnorm_addend = '0;
  logic [2:0]        shift = '0;
  logic [3:0]        threshold = 4'd10;
  logic [2:0]        refractory_cycles = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NEU-1:0]    out_spikes;
  logic [NEU*MB-1:0] out_membrane;
  state_t            dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  neuron_lif_layer #(.SYNAPSES(SYN), .NEURONS(NEU)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .inputs            (inputs),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_weights       (cfg_weights),
    .cfg_ready         (cfg_ready),
    .batchnorm_factor  (batchnorm_factor),
    .batchnorm_addend  (batchnorm_addend),
    .shift             (shift),
    .threshold         (threshold),
    .refractory_cycles (refractory_cycles),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_spikes        (out_spikes),
    .out_membrane      (out_membrane),
    .dbg_state         (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] mem_at(input int i);
    logic signed [MB-1:0] m;
    m = out_membrane[i*MB +: MB];
    return 32'(m);
  endfunction

  task automatic write_row(input int a, input logic [SYN-1:0] w);
    cfg_we      = 1'b1;
    cfg_addr    = 2'(a);
    cfg_weights = w;
    tick;
    cfg_we      = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic accept(input logic [SYN-1:0] vec);
    int n;
    n        = 0;
    inputs   = vec;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    check("accept_wait", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    check("run.in_ready", 32'(in_ready), 0);
    check("run.cfg_ready", 32'(cfg_ready), 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick;
      n++;
    end
    check({tag, ".latency"}, n, NEU);
  endtask

  task automatic check_outputs(input string tag, input logic [NEU-1:0] spk,
                               input int e0, input int e1, input int e2, input int e3);
    int e [NEU];
    e = '{e0, e1, e2, e3};
    check({tag, ".spikes"}, 32'(out_spikes), 32'(spk));
    for (int i = 0; i < NEU; i++) check($sformatf("%s.mem%0d", tag, i), mem_at(i), e[i]);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, ".out_valid_cleared"}, 32'(out_valid), 0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 1);
  endtask

  task automatic step(input string tag, input logic [SYN-1:0] vec, input logic [NEU-1:0] spk,
                      input int e0, input int e1, input int e2, input int e3);
    accept(vec);
    wait_done(tag);
    check_outputs(tag, spk, e0, e1, e2, e3);
    consume(tag);
  endtask

  initial begin
    bit stable;

    // Reset values
    tick;
    reset = 1'b1;
    tick;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_spikes", 32'(out_spikes), 0);
    check("rst.out_membrane", 32'(out_membrane), 0);
    check("rst.in_ready_low", 32'(in_ready), 0);
    check("rst.cfg_ready_low", 32'(cfg_ready), 0);
    reset = 1'b0;
    tick;
    check("rst.in_ready_high", 32'(in_ready), 1);
    check("rst.cfg_ready_high", 32'(cfg_ready), 1);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));

    // Integration, backpressure, refractory
    for (int r = 0; r < NEU; r++) write_row(r, 8'hFF);
    threshold         = 4'd10;
    refractory_cycles = 3'd2;
    step("int1", 8'h0F, 4'h0, 4, 4, 4, 4);
    step("int2", 8'h0F, 4'h0, 8, 8, 8, 8);
    accept(8'h0F);
    wait_done("int3");
    check_outputs("int3", 4'hF, 0, 0, 0, 0);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (out_valid !== 1'b1 || out_spikes !== 4'hF || in_ready !== 1'b0 ||
          out_membrane !== '0) stable = 1'b0;
    end
    check("bp.stable", 32'(stable), 1);
    consume("bp");
    check("bp.state_idle", 32'(dbg_state), 32'(ST_IDLE));
`ifdef NEURON_LIF_LAYER_REFRACTORY_EN
    step("refr4", 8'h0F, 4'h0, 0, 0, 0, 0);
    step("refr5", 8'h0F, 4'h0, 0, 0, 0, 0);
    step("refr6", 8'h0F, 4'h0, 4, 4, 4, 4);
`else
    step("refr4", 8'h0F, 4'h0, 4, 4, 4, 4);
    step("refr5", 8'h0F, 4'h0, 8, 8, 8, 8);
    step("refr6", 8'h0F, 4'hF, 0, 0, 0, 0);
`endif
    refractory_cycles = 3'd0;

    // Per-neuron weights; row 3 written in the accept cycle, RUN writes ignored
    do_reset;
    write_row(0, 8'hFF);
    write_row(1, 8'h00);
    write_row(2, 8'h0F);
    cfg_we      = 1'b1;
    cfg_addr    = 2'd3;
    cfg_weights = 8'h0F;
    accept(8'hFF);
    cfg_addr    = 2'd0;
    cfg_weights = 8'h00;
    wait_done("pn1");
    cfg_we = 1'b0;
    check_outputs("pn1", 4'h0, 8, -8, 0, 0);
    consume("pn1");
    step("pn2", 8'hFF, 4'h1, 0, -16, 0, 0);
    step("pn3", 8'hFF, 4'h0, 8, -16, 0, 0);

    // Leak, batch-norm scale/offset, threshold equality
    do_reset;
    write_row(0, 8'hFF);
    write_row(1, 8'h00);
    write_row(2, 8'h03);
    write_row(3, 8'h07);
    shift            = 3'd1;
    batchnorm_factor = 4'b0110;
    batchnorm_addend = -3'sd1;
    threshold        = 4'd15;
    step("bn1", 8'h0F, 4'h0, 5, -7, -1, 2);
    step("bn2", 8'h0F, 4'h0, 9, -12, -1, 3);
    threshold = 4'd12;
    step("bn3", 8'h0F, 4'h1, 0, -16, -1, 5);

    // Saturation before and after batch-norm
    do_reset;
    for (int r = 0; r < NEU; r++) write_row(r, 8'hFF);
    shift            = 3'd0;
    batchnorm_factor = BN_UNITY;
    batchnorm_addend = 3'sd0;
    threshold        = 4'd15;
    step("sat1", 8'hFF, 4'h0, 8, 8, 8, 8);
    batchnorm_factor = 4'b0010;
    batchnorm_addend = 3'sd3;
    step("sat2", 8'hFF, 4'h0, 10, 10, 10, 10);
    batchnorm_factor = 4'b1111;
    step("sat3", 8'hFF, 4'hF, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a sweep
    do_reset;
    for (int r = 0; r < NEU; r++) write_row(r, 8'hFF);
    batchnorm_factor = BN_UNITY;
    batchnorm_addend = 3'sd0;
    step("mid1", 8'h0F, 4'h0, 4, 4, 4, 4);
    accept(8'h0F);
    tick;
    tick;
    #2;
    reset = 1'b1;
    #1;
    check("mid.state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid.out_valid", 32'(out_valid), 0);
    check("mid.membrane", 32'(out_membrane), 0);
    check("mid.in_ready", 32'(in_ready), 0);
    tick;
    reset = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) stable = 1'b0;
    end
    check("mid.stays_idle", 32'(stable), 1);
    for (int r = 0; r < NEU; r++) write_row(r, 8'hFF);
    step("mid2", 8'h0F, 4'h0, 4, 4, 4, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
